adc_capture_buffer: RTL and testbench
=====================================

ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning ADC sample width per channel in bits.
REQ-002 SHALL have parameter NUM_CH, default 2, meaning number of parallel ADC channels.
REQ-003 SHALL have parameter DEPTH, default 256, meaning capture depth in sample slots; power of 2, 16 or more; AW = log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  qualifies in_data/in_or this cycle.
REQ-007 SHALL have port in_data  input  NUM_CH*DATA_W  two's-complement samples, channel c at bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port in_or  input  NUM_CH  per-channel overrange flag.
REQ-009 SHALL have port arm  input  1  one-cycle pulse that starts a capture.
REQ-010 SHALL have port abort  input  1  returns the block to IDLE.
REQ-011 SHALL have port trig_mode  input  1  0 = software trigger, 1 = level trigger.
REQ-012 SHALL have port sw_trig  input  1  software trigger pulse.
REQ-013 SHALL have port trig_ch  input  max(1,log2(NUM_CH))  channel watched by the level trigger.
REQ-014 SHALL have port trig_level  input  DATA_W  signed threshold.
REQ-015 SHALL have port pre_count  input  AW  number of pre-trigger samples.
REQ-016 SHALL have port rd_valid/rd_ready  output/input  1/1  readout handshake.
REQ-017 SHALL have port rd_data/rd_or/rd_last  output  NUM_CH*DATA_W / NUM_CH / 1  readout sample, its overrange flags, final-beat marker.
REQ-018 SHALL have port state  output  3  IDLE=0, PRE=1, WAIT=2, POST=3, READ=4.
REQ-019 SHALL have port or_sticky/clear_or  output/input  NUM_CH/1  sticky overrange flags and their clear.

Function
REQ-020 SHALL store each in_valid sample (all channels plus in_or) into a DEPTH-entry circular buffer; write address increments mod DEPTH, on in_valid only, in PRE, WAIT and POST.
REQ-021 SHALL latch pre_count on arm; IDLE->PRE on arm; arm outside IDLE ignored.
REQ-022 SHALL count written samples in PRE; PRE->WAIT once the count equals the latched pre_count (pre_count=0: PRE->WAIT next cycle); triggers in PRE ignored.
REQ-023 SHALL, in WAIT and mode 0, trigger on the first in_valid sample at or after an sw_trig pulse; sw_trig while in_valid=0 stays pending until the next valid sample.
REQ-024 SHALL, in WAIT and mode 1, trigger on a valid sample whose trig_ch value is >= trig_level (signed) while the previous valid sample on that channel was < trig_level; the previous sample is tracked from PRE onward.
REQ-025 SHALL store the trigger sample as the first post-trigger sample, record its address as trig_addr, and move WAIT->POST.
REQ-026 SHALL collect DEPTH-pre_count samples in POST, trigger sample included, then POST->READ.
REQ-027 SHALL, in READ, present DEPTH beats starting at address (trig_addr - pre_count) mod DEPTH, oldest first.
REQ-028 SHALL assert the first rd_valid within 2 cycles of entering READ.
REQ-029 SHALL hold rd_data, rd_or and rd_last stable while rd_valid=1 and rd_ready=0.
REQ-030 SHALL allow back-to-back beats at one per cycle while rd_ready=1.
REQ-031 SHALL assert rd_last on beat DEPTH only; after that handshake, READ->IDLE and rd_valid=0 next cycle.
REQ-032 SHALL let abort take priority over every other input, forcing IDLE next cycle and dropping rd_valid; buffer contents are undefined after an abort.
REQ-033 SHALL set or_sticky[c] on in_valid & in_or[c] in any state and clear it on clear_or; set wins over clear in the same cycle.
REQ-034 SHALL count a simultaneous sw_trig and level crossing as a single trigger.

Reset
REQ-035 SHALL, while reset=0 and independent of clk, force state=IDLE, rd_valid=0, rd_last=0, rd_data=0, rd_or=0, or_sticky=0, all address and sample counters 0, and clear any pending sw_trig.
REQ-036 SHALL, on reset mid-capture or mid-readout, discard the capture; the first cycle after release is IDLE.

Verification
REQ-037 SHALL cover: DEPTH=16, NUM_CH=2, pre_count=4, mode 0, ramp input 0,1,2..., sw_trig when the sample value is 10 -> 16 beats reading 6..21, rd_last on value 21.
REQ-038 SHALL cover: mode 1, trig_level=100, ch1 steps 50->150 with ch0 constant -> the trigger sample is the first 150 and sits at beat pre_count+1; a value already >=100 on entering WAIT does not trigger.
REQ-039 SHALL cover: sw_trig pulsed during PRE -> ignored, state stays WAIT until a new sw_trig arrives.
REQ-040 SHALL cover: readout with rd_ready toggled randomly and stalls of up to 5 cycles -> no beat lost or duplicated, data stable during stalls.
REQ-041 SHALL cover: in_or[1]=1 on one sample plus clear_or in the same cycle -> or_sticky[1]=1; rd_or[1]=1 only on that beat.
REQ-042 SHALL cover: reset driven low in POST and in READ -> outputs reach reset values without a clk edge; arm after release completes a full capture.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC capture buffer: circular pre/post-trigger capture with software or
// level trigger, then a ready/valid readout of DEPTH beats starting at the oldest sample.
module adc_capture_buffer #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_or,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_mode,
    input  logic                     sw_trig,
    input  logic [CW-1:0]            trig_ch,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic [AW-1:0]            pre_count,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]        rd_or,
    output logic                     rd_last,
    output logic [2:0]               state,
    output logic [NUM_CH-1:0]        or_sticky,
    input  logic                     clear_or
);

    // States: IDLE wait arm | PRE fill pre-trigger | WAIT armed | POST fill post-trigger | READ drain
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_READ = 3'd4
    } state_t;

    localparam int             SLOT_W   = NUM_CH * (DATA_W + 1);
    localparam logic [AW-1:0]  LP_ONE   = AW'(1);
    localparam logic [AW-1:0]  LP_MAX   = AW'(DEPTH - 1);
    localparam logic [AW:0]    LP_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    LP_LAST  = (AW + 1)'(1);

    state_t                    r_state, w_state_nxt;
    logic [SLOT_W-1:0]         r_mem [DEPTH];
    logic [AW-1:0]             r_wr_addr, r_rd_addr, r_trig_addr, r_cnt, r_pre;
    logic [AW:0]               r_rd_left;
    logic                      r_sw_pend, r_prev_vld;
    logic signed [DATA_W-1:0]  r_prev_smp;
    logic                      r_rd_valid, r_rd_last;
    logic [NUM_CH*DATA_W-1:0]  r_rd_data;
    logic [NUM_CH-1:0]         r_rd_or, r_or_sticky;

    logic signed [DATA_W-1:0]  w_ch [NUM_CH];
    logic signed [DATA_W-1:0]  w_cur;
    logic [SLOT_W-1:0]         w_rd_word;
    logic                      w_cnt_done, w_trig_sw, w_trig_lvl;
    logic                      w_trig, w_we, w_track, w_rd_load, w_rd_take;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch[g] = in_data[g*DATA_W +: DATA_W];
    end

    assign w_cur      = w_ch[trig_ch];
    assign w_rd_word  = r_mem[r_rd_addr];
    // Down-counter terminal count: already zero, or this valid sample exhausts it.
    assign w_cnt_done = (r_cnt == '0) || (in_valid && (r_cnt == LP_ONE));
    assign w_trig_sw  = !trig_mode && in_valid && (sw_trig || r_sw_pend);
    assign w_trig_lvl = trig_mode && in_valid && r_prev_vld
                        && (w_cur >= $signed(trig_level))
                        && (r_prev_smp < $signed(trig_level));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (arm)                     w_state_nxt = S_PRE;
            S_PRE:   if (w_cnt_done)              w_state_nxt = S_WAIT;
            S_WAIT:  if (w_trig)                  w_state_nxt = S_POST;
            S_POST:  if (w_cnt_done)              w_state_nxt = S_READ;
            S_READ:  if (w_rd_take && r_rd_last)  w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_we      = 1'b0;
        w_track   = 1'b0;
        w_trig    = 1'b0;
        w_rd_load = 1'b0;
        w_rd_take = 1'b0;
        case (r_state)
            S_PRE:  begin w_we = 1'b1; w_track = 1'b1; end
            S_WAIT: begin w_we = 1'b1; w_track = 1'b1; w_trig = w_trig_sw || w_trig_lvl; end
            // Once the post count is exhausted, further samples would overwrite the oldest pre-trigger slot.
            S_POST: begin w_we = (r_cnt != '0); w_track = 1'b1; end
            S_READ: begin
                w_rd_load = (r_rd_left != '0) && (!r_rd_valid || rd_ready);
                w_rd_take = r_rd_valid && rd_ready;
            end
            default: ;
        endcase
        w_we = w_we && in_valid && !abort;
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_addr] <= {in_or, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_trig_addr <= '0;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_rd_left   <= '0;
            r_sw_pend   <= 1'b0;
            r_prev_vld  <= 1'b0;
            r_prev_smp  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_or     <= '0;
            r_or_sticky <= '0;
        end else begin
            if (w_we) r_wr_addr <= r_wr_addr + LP_ONE;
            if (in_valid && w_track) begin
                r_prev_smp <= w_cur;
                r_prev_vld <= 1'b1;
            end
            if (abort) begin
                r_sw_pend  <= 1'b0;
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (arm) begin
                        r_pre      <= pre_count;
                        r_cnt      <= pre_count;
                        r_prev_vld <= 1'b0;
                        r_sw_pend  <= 1'b0;
                    end
                    S_PRE: if (in_valid && (r_cnt != '0)) r_cnt <= r_cnt - LP_ONE;
                    S_WAIT: begin
                        if (w_trig) begin
                            r_trig_addr <= r_wr_addr;
                            r_cnt       <= LP_MAX - r_pre;
                            r_sw_pend   <= 1'b0;
                        end else if (sw_trig && !in_valid) begin
                            r_sw_pend <= 1'b1;
                        end
                    end
                    S_POST: begin
                        if (in_valid && (r_cnt != '0)) r_cnt <= r_cnt - LP_ONE;
                        if (w_state_nxt == S_READ) begin
                            r_rd_addr <= r_trig_addr - r_pre;
                            r_rd_left <= LP_DEPTH;
                        end
                    end
                    S_READ: begin
                        if (w_rd_load) begin
                            r_rd_data  <= w_rd_word[NUM_CH*DATA_W-1:0];
                            r_rd_or    <= w_rd_word[SLOT_W-1 -: NUM_CH];
                            r_rd_last  <= (r_rd_left == LP_LAST);
                            r_rd_valid <= 1'b1;
                            r_rd_addr  <= r_rd_addr + LP_ONE;
                            r_rd_left  <= r_rd_left - LP_LAST;
                        end else if (w_rd_take) begin
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            r_or_sticky <= (r_or_sticky & ~{NUM_CH{clear_or}}) | (in_valid ? in_or : '0);
        end
    end

    assign state     = r_state;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_or     = r_rd_or;
    assign rd_last   = r_rd_last;
    assign or_sticky = r_or_sticky;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: directed capture scenarios with random data, gaps and
// readout stalls; expected beats come from a stream-index model of the captured samples.
module tb_adc_capture_buffer;
    localparam int DW = 16;
    localparam int NC = 2;
    localparam int DP = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]    in_or;
    logic             arm, abort, trig_mode, sw_trig;
    logic             trig_ch;
    logic [DW-1:0]    trig_level;
    logic [3:0]       pre_count;
    logic             rd_valid, rd_ready, rd_last, clear_or;
    logic [NC*DW-1:0] rd_data;
    logic [NC-1:0]    rd_or, or_sticky;
    logic [2:0]       state;

    int checks = 0;
    int failures = 0;
    logic [33:0] strm [$];
    int trig_idx;

    adc_capture_buffer #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_or(in_or),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .sw_trig(sw_trig),
        .trig_ch(trig_ch), .trig_level(trig_level), .pre_count(pre_count),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_or(rd_or),
        .rd_last(rd_last), .state(state), .or_sticky(or_sticky), .clear_or(clear_or)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = $urandom;
            tick();
        end
    endtask

    task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] o,
                        input logic sw, input logic clr);
        in_valid = 1'b1;
        in_data  = {d1, d0};
        in_or    = o;
        sw_trig  = sw;
        clear_or = clr;
        tick();
        strm.push_back({o, d1, d0});
        in_valid = 1'b0;
        sw_trig  = 1'b0;
        clear_or = 1'b0;
        in_or    = 2'b00;
        in_data  = $urandom;
    endtask

    task automatic send_rnd(input bit with_or);
        logic [1:0] o;
        o = (with_or && $urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        if ($urandom_range(0, 3) == 0) idle(1);
        send(16'($urandom), 16'($urandom), o, 1'b0, 1'b0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic do_arm(input logic [3:0] pc);
        strm.delete();
        pre_count = pc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        pre_count = 4'($urandom);
        chk("arm_to_pre", state, 3'd1);
    endtask

    task automatic capture(input int pc);
        do_arm(4'(pc));
        for (int i = 0; i < pc; i++) send_rnd(1'b1);
        wait_state(3'd2, 4, "cap_wait");
        repeat ($urandom_range(0, 20)) send_rnd(1'b1);
        trig_idx = strm.size();
        send(16'($urandom), 16'($urandom), 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < DP - pc - 1; i++) send_rnd(1'b1);
        wait_state(3'd4, 4, "cap_read");
    endtask

    task automatic read_all(input int pre, input bit rnd, input string tag);
        int base, beat, stall, n;
        bit held_v, rdy;
        logic [34:0] held, cur;
        logic [33:0] e;
        base = trig_idx - pre;
        beat = 0; stall = 0; n = 0; held_v = 0; held = '0;
        rd_ready = 1'b0;
        while (rd_valid !== 1'b1 && n < 2) begin
            tick();
            n++;
        end
        chk({tag, "_first_valid"}, rd_valid, 1'b1);
        n = 0;
        while (beat < DP && n < 300) begin
            cur = {rd_last, rd_or, rd_data};
            if (held_v) chk({tag, "_stall_hold"}, {rd_valid, cur}, {1'b1, held});
            rdy = !rnd || stall >= 5 || ($urandom_range(0, 1) == 1);
            rd_ready = rdy;
            if (rd_valid === 1'b1 && rdy) begin
                e = (base + beat < strm.size()) ? strm[base + beat] : 'x;
                chk({tag, "_beat_data"}, rd_data, e[31:0]);
                chk({tag, "_beat_or"}, rd_or, e[33:32]);
                chk({tag, "_beat_last"}, rd_last, (beat == DP - 1));
                beat++;
                held_v = 0;
                stall = 0;
            end else if (rd_valid === 1'b1) begin
                held_v = 1;
                held = cur;
                stall++;
            end else begin
                held_v = 0;
            end
            tick();
            n++;
        end
        rd_ready = 1'b0;
        chk({tag, "_beat_count"}, beat, DP);
        chk({tag, "_done_valid"}, rd_valid, 1'b0);
        chk({tag, "_done_state"}, state, 3'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 3'd0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_last"}, rd_last, 1'b0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_rd_or"}, rd_or, 2'b00);
        chk({tag, "_or_sticky"}, or_sticky, 2'b00);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_or = '0; arm = 1'b0; abort = 1'b0;
        trig_mode = 1'b0; sw_trig = 1'b0; trig_ch = 1'b0; trig_level = '0; pre_count = '0;
        rd_ready = 1'b0; clear_or = 1'b0;
        #1;
        chk_reset_vals("por");
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        tick();
        chk("idle_after_reset", state, 3'd0);

        // Ramp capture with software trigger on value 10.
        trig_mode = 1'b0;
        do_arm(4'd4);
        for (int v = 0; v <= 21; v++) begin
            if (v == 10) trig_idx = strm.size();
            send(16'(v), 16'(16'h8000 ^ v), 2'b00, (v == 10), 1'b0);
            if (v == 9)  chk("ramp_wait", state, 3'd2);
            if (v == 10) chk("ramp_post", state, 3'd3);
        end
        chk("ramp_read", state, 3'd4);
        read_all(4, 1'b0, "ramp");

        // sw_trig in PRE ignored, arm in WAIT ignored, pending sw_trig, overrange with clear.
        do_arm(4'd3);
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send_rnd(1'b0);
        chk("pre_sw_ignored", state, 3'd2);
        pre_count = 4'd9;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_in_wait_ignored", state, 3'd2);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        idle(2);
        chk("sw_pending_wait", state, 3'd2);
        trig_idx = strm.size();
        send(16'($urandom), 16'($urandom), 2'b00, 1'b0, 1'b0);
        chk("sw_pending_fired", state, 3'd3);
        for (int i = 0; i < DP - 4; i++) begin
            if (i == 4) begin
                send(16'($urandom), 16'($urandom), 2'b10, 1'b0, 1'b1);
                chk("or_set_beats_clear", or_sticky, 2'b10);
            end else begin
                send_rnd(1'b0);
            end
        end
        wait_state(3'd4, 4, "t2_read");
        read_all(3, 1'b1, "pend");
        clear_or = 1'b1;
        tick();
        clear_or = 1'b0;
        chk("or_cleared", or_sticky, 2'b00);

        // Level trigger on ch1 at 100; already-above on entry and negative samples must not fire.
        trig_mode = 1'b1;
        trig_ch = 1'b1;
        trig_level = 16'd100;
        do_arm(4'd5);
        send(16'd7, 16'd30, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'd40, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'd50, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'd150, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'd150, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(16'd7, 16'd150, 2'b00, 1'b0, 1'b0);
        chk("lvl_above_on_entry", state, 3'd2);
        send(16'd7, 16'd50, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'hFF38, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'hFF38, 2'b00, 1'b0, 1'b0);
        send(16'd7, 16'd50, 2'b00, 1'b0, 1'b0);
        chk("lvl_negative_no_fire", state, 3'd2);
        trig_idx = strm.size();
        send(16'd7, 16'd150, 2'b00, 1'b0, 1'b0);
        chk("lvl_fired", state, 3'd3);
        for (int i = 0; i < DP - 6; i++) send(16'd7, 16'($urandom), 2'b00, 1'b0, 1'b0);
        wait_state(3'd4, 4, "lvl_read");
        read_all(5, 1'b1, "lvl");

        // Boundary pre_count values, random overrange flags, wrap in WAIT.
        trig_mode = 1'b0;
        capture(15);
        read_all(15, 1'b1, "pre15");
        capture(0);
        read_all(0, 1'b0, "pre0");

        // Abort wins over a simultaneous trigger; abort drops rd_valid in READ.
        do_arm(4'd2);
        send_rnd(1'b0);
        send_rnd(1'b0);
        wait_state(3'd2, 4, "abort_wait");
        abort = 1'b1;
        send(16'($urandom), 16'($urandom), 2'b00, 1'b1, 1'b0);
        abort = 1'b0;
        chk("abort_in_wait", state, 3'd0);
        idle(2);
        chk("abort_stays_idle", state, 3'd0);
        capture(5);
        tick();
        chk("abort_read_valid_before", rd_valid, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_read_valid", rd_valid, 1'b0);
        chk("abort_read_state", state, 3'd0);

        // Asynchronous reset in POST and in READ.
        do_arm(4'd3);
        for (int i = 0; i < 3; i++) send_rnd(1'b0);
        wait_state(3'd2, 4, "rst_post_wait");
        send(16'($urandom), 16'($urandom), 2'b00, 1'b1, 1'b0);
        send(16'($urandom), 16'($urandom), 2'b01, 1'b0, 1'b0);
        send(16'($urandom), 16'($urandom), 2'b01, 1'b0, 1'b0);
        chk("rst_post_state", state, 3'd3);
        chk("rst_post_sticky", or_sticky[0], 1'b1);
        #3 reset = 1'b0;
        #1 chk_reset_vals("rst_in_post");
        #3 reset = 1'b1;
        tick();
        chk("rst_post_release", state, 3'd0);

        capture(7);
        tick();
        chk("rst_read_valid_before", rd_valid, 1'b1);
        #3 reset = 1'b0;
        #1 chk_reset_vals("rst_in_read");
        #3 reset = 1'b1;
        tick();
        chk("rst_read_release", state, 3'd0);
        capture(4);
        read_all(4, 1'b1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
